// File: rtl/event_counter_pkg.sv
// event_counter_pkg: shared state encoding and limits for the event counter scheduler
package event_counter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;
  localparam int NUM_REQ_MAX      = 8;
  localparam int TARGET_WIDTH_DEF = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, priority rotating from ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] k;
  // scan from farthest to nearest so the requester closest to ptr wins last
  always_comb begin
    gnt_idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) gnt_idx = k;
    end
    gnt = (|req) ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/event_counter_sched.sv
// event_counter_sched: round-robin time-sharing of one event_counter among requesters
module event_counter_sched
  import event_counter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int TARGET_WIDTH = TARGET_WIDTH_DEF
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              REQ,
  input  logic [NUM_REQ*TARGET_WIDTH-1:0] REQ_INITIAL,
  input  logic [NUM_REQ*TARGET_WIDTH-1:0] REQ_TARGET,
  output logic [NUM_REQ-1:0]              GNT,
  output logic [NUM_REQ-1:0]              DONE,
  output logic                            BUSY,
  output logic                            EC_ARESETN,
  output logic                            EC_ENABLE,
  output logic [TARGET_WIDTH-1:0]         EC_INITIAL,
  output logic [TARGET_WIDTH-1:0]         EC_TARGET,
  input  logic                            EC_REACHED
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nxt;
  logic [IW-1:0] rr_ptr, win, win_nxt, arb_idx;
  logic [NUM_REQ-1:0] arb_gnt, win_oh;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(REQ),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .gnt_idx(arb_idx)
  );

  // next state and winner; REACHED takes precedence over a dropped request in RUN
  always_comb begin
    state_nxt = state;
    win_nxt = win;
    case (state)
      ST_IDLE: if (|REQ) begin
        state_nxt = ST_LOAD;
        win_nxt = arb_idx;
      end
      ST_LOAD: state_nxt = (EC_INITIAL == EC_TARGET) ? ST_DONE : ST_RUN;
      ST_RUN:  state_nxt = EC_REACHED ? ST_DONE : (!REQ[win] ? ST_ABORT : ST_RUN);
      default: state_nxt = ST_IDLE;
    endcase
    win_oh = (state == ST_IDLE) ? arb_gnt : NUM_REQ'(1) << win;
  end

  // state, window latch, pointer advance and outputs registered from the next state
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= ST_IDLE;
      rr_ptr <= '0;
      win <= '0;
      GNT <= '0;
      DONE <= '0;
      BUSY <= 1'b0;
      EC_ARESETN <= 1'b1;
      EC_ENABLE <= 1'b0;
      EC_INITIAL <= '0;
      EC_TARGET <= '0;
    end else begin
      state <= state_nxt;
      win <= win_nxt;
      if (state == ST_IDLE && |REQ) begin
        EC_INITIAL <= REQ_INITIAL[arb_idx*TARGET_WIDTH +: TARGET_WIDTH];
        EC_TARGET <= REQ_TARGET[arb_idx*TARGET_WIDTH +: TARGET_WIDTH];
      end
      if (state == ST_DONE || state == ST_ABORT)
        rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      GNT <= (state_nxt == ST_LOAD || state_nxt == ST_RUN || state_nxt == ST_DONE) ? win_oh : '0;
      DONE <= (state_nxt == ST_DONE) ? win_oh : '0;
      BUSY <= state_nxt != ST_IDLE;
      EC_ARESETN <= state_nxt != ST_LOAD;
      EC_ENABLE <= state_nxt == ST_RUN;
    end
  end
endmodule

// File: tb/tb_event_counter_sched.sv
// tb_event_counter_sched: directed scenarios against a behavioural scheduler model
module tb_event_counter_sched;
  localparam int N = 4;
  localparam int W = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3, P_ABORT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_init = '0;
  logic [N*W-1:0] req_tgt = '0;
  logic [N-1:0] gnt, done;
  logic busy, ec_aresetn, ec_enable, ec_reached;
  logic [W-1:0] ec_initial, ec_target;
  int checks = 0;
  int failures = 0;
  logic cmp_on = 1'b0;

  event_counter_sched #(.NUM_REQ(N), .TARGET_WIDTH(W)) dut (
    .ACLK(clk),
    .ARESET(rst),
    .REQ(req),
    .REQ_INITIAL(req_init),
    .REQ_TARGET(req_tgt),
    .GNT(gnt),
    .DONE(done),
    .BUSY(busy),
    .EC_ARESETN(ec_aresetn),
    .EC_ENABLE(ec_enable),
    .EC_INITIAL(ec_initial),
    .EC_TARGET(ec_target),
    .EC_REACHED(ec_reached)
  );

  always #5 clk = ~clk;

  // stand-in for the attached event_counter: reload on strobe, count on enabled ticks
  logic [W-1:0] cnt = '0;
  logic tick = 1'b1;
  int tick_div = 1;
  always @(posedge clk) begin
    tick <= (tick_div == 1) ? 1'b1 : ~tick;
    if (!ec_aresetn) cnt <= ec_initial;
    else if (ec_enable && tick) cnt <= cnt + 1'b1;
  end
  assign ec_reached = ec_enable && (cnt == ec_target);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: service phase, current winner, pointer and latched window
  int ph = P_IDLE;
  int m_win = 0;
  int m_ptr = 0;
  logic [W-1:0] m_ini = '0;
  logic [W-1:0] m_tgt = '0;
  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE; m_ptr = 0; m_win = 0; m_ini = '0; m_tgt = '0;
    end else if (ph == P_IDLE) begin
      for (int k = 0; k < N; k++)
        if (ph == P_IDLE && req[(m_ptr + k) % N]) begin
          m_win = (m_ptr + k) % N;
          ph = P_LOAD;
          m_ini = req_init[m_win*W +: W];
          m_tgt = req_tgt[m_win*W +: W];
        end
    end else if (ph == P_LOAD) ph = (m_ini == m_tgt) ? P_DONE : P_RUN;
    else if (ph == P_RUN) begin
      if (ec_reached) ph = P_DONE;
      else if (!req[m_win]) ph = P_ABORT;
    end else begin
      m_ptr = (m_win + 1) % N;
      ph = P_IDLE;
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [N-1:0] oh;
    if (cmp_on) begin
      oh = '0;
      oh[m_win] = 1'b1;
      check("m_gnt", gnt, (ph == P_LOAD || ph == P_RUN || ph == P_DONE) ? oh : '0);
      check("m_done", done, (ph == P_DONE) ? oh : '0);
      check("m_busy", busy, ph != P_IDLE);
      check("m_aresetn", ec_aresetn, ph != P_LOAD);
      check("m_enable", ec_enable, ph == P_RUN);
      check("m_initial", ec_initial, m_ini);
      check("m_target", ec_target, m_tgt);
    end
  end

  // log each new grant index in order
  int gq[$];
  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (gnt != 0 && prev_gnt == 0)
      for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
    prev_gnt = gnt;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_win(input int i, input int ini, input int tgt);
    req_init[i*W +: W] = W'(ini);
    req_tgt[i*W +: W] = W'(tgt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_aresetn"}, ec_aresetn, 1);
    check({tag, "_enable"}, ec_enable, 0);
    check({tag, "_initial"}, ec_initial, 0);
    check({tag, "_target"}, ec_target, 0);
  endtask

  initial begin
    int nd;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    step(1);
    cmp_on = 1'b1;
    step(1);
    check_reset_vals("rst0");
    rst = 1'b0;

    // single request, slow ticks
    tick_div = 2;
    set_win(0, 0, 6);
    req = 4'b0001;
    step(1);
    check("t1_gnt", gnt, 4'b0001);
    check("t1_aresetn_low", ec_aresetn, 0);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_enable", ec_enable, 1);
    for (int i = 0; i < 100 && !(ec_reached && ec_enable); i++) step(1);
    check("t1_reached_seen", ec_reached && ec_enable, 1);
    step(1);
    check("t1_done", done, 4'b0001);
    req = '0;
    step(1);
    check("t1_busy_low", busy, 0);
    check("t1_done_clear", done, 0);

    // round robin with all four requesting
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    tick_div = 1;
    for (int i = 0; i < N; i++) set_win(i, 0, 2);
    gq.delete();
    req = 4'b1111;
    nd = 0;
    for (int i = 0; i < 200 && nd < 5; i++) begin
      step(1);
      if (done != 0) nd++;
    end
    req = '0;
    check("t2_done_count", nd, 5);
    step(3);
    check("t2_grant_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) check("t2_order", gq[i], exp_order[i]);

    // initial equals target: no counting
    set_win(2, 5, 5);
    req = 4'b0100;
    step(1);
    check("t3_gnt", gnt, 4'b0100);
    check("t3_enable_load", ec_enable, 0);
    step(1);
    check("t3_done", done, 4'b0100);
    check("t3_enable_done", ec_enable, 0);
    req = '0;
    step(1);
    check("t3_busy_low", busy, 0);

    // abort of requester 1 at count 3, requester 2 then served
    set_win(1, 0, 9);
    set_win(2, 0, 1);
    req = 4'b0010;
    for (int i = 0; i < 100 && !(ec_enable && cnt == 4'd3); i++) step(1);
    check("t4_at_three", ec_enable && cnt == 4'd3, 1);
    check("t4_gnt_run", gnt, 4'b0010);
    req = 4'b0100;
    step(1);
    check("t4_enable_off", ec_enable, 0);
    check("t4_no_done", done, 0);
    step(2);
    check("t4_next_gnt", gnt, 4'b0100);
    for (int i = 0; i < 100 && done == 0; i++) step(1);
    check("t4_done2", done, 4'b0100);
    req = '0;
    step(2);

    // REACHED and request drop in the same RUN cycle
    set_win(0, 0, 3);
    req = 4'b0001;
    for (int i = 0; i < 100 && !(ec_reached && ec_enable); i++) step(1);
    check("t5_reached_seen", ec_reached && ec_enable, 1);
    req = '0;
    step(1);
    check("t5_done", done, 4'b0001);
    step(1);
    check("t5_idle", busy, 0);
    check("t5_no_extra_done", done, 0);

    // reset while requester 2 runs, then requester 2 wins first again
    set_win(2, 0, 9);
    set_win(3, 0, 9);
    req = 4'b1100;
    for (int i = 0; i < 100 && !(gnt == 4'b0100 && ec_enable); i++) step(1);
    check("t6_running", gnt == 4'b0100 && ec_enable, 1);
    rst = 1'b1;
    step(1);
    check_reset_vals("t6_rst");
    rst = 1'b0;
    step(1);
    check("t6_first_gnt", gnt, 4'b0100);
    check("t6_aresetn_low", ec_aresetn, 0);
    req = '0;
    step(4);
    check("t6_idle", busy, 0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
